// File: rtl/led_pwm_pio_pkg.sv
// Shared register offsets and types for the PWM-capable LED peripheral.
package led_pio_pkg;

    localparam logic [4:0] ADDR_DATA      = 5'd0;
    localparam logic [4:0] ADDR_MODE      = 5'd1;
    localparam logic [4:0] ADDR_PRESCALE  = 5'd2;
    localparam logic [4:0] ADDR_STATUS    = 5'd3;
    localparam logic [4:0] ADDR_DUTY_BASE = 5'd16;

    typedef enum logic {
        LED_STATIC = 1'b0,
        LED_PWM    = 1'b1
    } led_mode_t;

endpackage

// File: rtl/led_pwm_pio_if.sv
// Avalon-MM slave bus bundle for the LED peripheral.
interface led_pwm_pio_if;

    logic [4:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address,
        output avs_read,
        output avs_write,
        output avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address,
        input  avs_read,
        input  avs_write,
        input  avs_writedata,
        output avs_readdata
    );

endinterface

// File: rtl/led_pwm_pio_channel.sv
// One LED channel: double-buffered duty, counter compare and registered pin.
module led_pwm_channel
    import led_pio_pkg::*;
#(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                duty_we,
    input  logic [PWM_BITS:0]   duty_wdata,
    input  logic                wrap,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                enable,
    input  led_mode_t           mode,
    output logic [PWM_BITS:0]   duty_pending,
    output logic                led
);

    logic [PWM_BITS:0] duty_active;
    logic              pwm_on;

    // Pending duty follows bus writes immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_pending <= '0;
        end else if (duty_we) begin
            duty_pending <= duty_wdata;
        end
    end

    // Active duty only changes at a period boundary; a write on the wrap edge
    // is not yet visible in duty_pending, so the old value is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_active <= '0;
        end else if (wrap) begin
            duty_active <= duty_pending;
        end
    end

    // Extra MSB on the duty makes values >= 2^PWM_BITS compare always true.
    always_comb begin
        pwm_on = ({1'b0, pwm_cnt} < duty_active);
    end

    // Registered pin drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led <= 1'b0;
        end else begin
            led <= enable & ((mode == LED_PWM) ? pwm_on : 1'b1);
        end
    end

endmodule

// File: rtl/led_pwm_pio.sv
// Avalon-MM LED peripheral: static or PWM per LED, shared prescaler and counter.
module led_pwm_pio
    import led_pio_pkg::*;
#(
    parameter int unsigned NUM_LEDS      = 8,
    parameter int unsigned PWM_BITS      = 8,
    parameter int unsigned PRESCALE_BITS = 16
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    led_pwm_pio_if.slave        avs,
    output logic [NUM_LEDS-1:0] led_wire_export
);

    logic [NUM_LEDS-1:0]      data_reg;
    logic [NUM_LEDS-1:0]      mode_reg;
    logic [PRESCALE_BITS-1:0] prescale_reg;
    logic [PRESCALE_BITS-1:0] pre_cnt;
    logic [PWM_BITS-1:0]      pwm_cnt;
    logic                     wrap_flag;
    logic                     tick;
    logic                     wrap;
    logic                     wr_data;
    logic                     wr_mode;
    logic                     wr_prescale;
    logic                     rd_status;
    logic [NUM_LEDS-1:0]      duty_we;
    logic [PWM_BITS:0]        duty_pending [NUM_LEDS];
    logic [31:0]              rd_mux;

    assign wr_data     = avs.avs_write && (avs.avs_address == ADDR_DATA);
    assign wr_mode     = avs.avs_write && (avs.avs_address == ADDR_MODE);
    assign wr_prescale = avs.avs_write && (avs.avs_address == ADDR_PRESCALE);
    assign rd_status   = avs.avs_read  && (avs.avs_address == ADDR_STATUS);

    assign tick = (pre_cnt == prescale_reg);
    assign wrap = tick && (pwm_cnt == '1);

    // Control registers written from the bus.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            data_reg     <= '0;
            mode_reg     <= '0;
            prescale_reg <= '0;
        end else begin
            if (wr_data)     data_reg     <= avs.avs_writedata[NUM_LEDS-1:0];
            if (wr_mode)     mode_reg     <= avs.avs_writedata[NUM_LEDS-1:0];
            if (wr_prescale) prescale_reg <= avs.avs_writedata[PRESCALE_BITS-1:0];
        end
    end

    // Prescaler: counts 0..PRESCALE, restarts on tick or on a PRESCALE write.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pre_cnt <= '0;
        end else if (wr_prescale || tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // Free-running PWM counter, wraps naturally at full scale.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pwm_cnt <= '0;
        end else if (tick) begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // Wrap flag: a wrap on the same edge as a STATUS read keeps it set.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wrap_flag <= 1'b0;
        end else if (wrap) begin
            wrap_flag <= 1'b1;
        end else if (rd_status) begin
            wrap_flag <= 1'b0;
        end
    end

    // Read mux over pre-write register values.
    always_comb begin
        rd_mux = '0;
        case (avs.avs_address)
            ADDR_DATA:     rd_mux[NUM_LEDS-1:0]      = data_reg;
            ADDR_MODE:     rd_mux[NUM_LEDS-1:0]      = mode_reg;
            ADDR_PRESCALE: rd_mux[PRESCALE_BITS-1:0] = prescale_reg;
            ADDR_STATUS: begin
                rd_mux[0]             = wrap_flag;
                rd_mux[16 +: PWM_BITS] = pwm_cnt;
            end
            default: begin
                for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                    if (avs.avs_address == 5'(ADDR_DUTY_BASE + i)) begin
                        rd_mux[PWM_BITS:0] = duty_pending[i];
                    end
                end
            end
        endcase
    end

    // Read data registered for a fixed latency of one cycle.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            avs.avs_readdata <= '0;
        end else if (avs.avs_read) begin
            avs.avs_readdata <= rd_mux;
        end
    end

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
        assign duty_we[g] = avs.avs_write && (avs.avs_address == 5'(ADDR_DUTY_BASE + g));

        led_pwm_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .clk          (clk_clk),
            .rst_n        (reset_reset_n),
            .duty_we      (duty_we[g]),
            .duty_wdata   (avs.avs_writedata[PWM_BITS:0]),
            .wrap         (wrap),
            .pwm_cnt      (pwm_cnt),
            .enable       (data_reg[g]),
            .mode         (led_mode_t'(mode_reg[g])),
            .duty_pending (duty_pending[g]),
            .led          (led_wire_export[g])
        );
    end

endmodule

// File: tb/tb_led_pwm_pio.sv
// Directed bench for led_pwm_pio: an 8-LED and a 3-LED instance share one clock.
module tb_led_pwm_pio;
    import led_pio_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    led_pwm_pio_if bus8();
    led_pwm_pio_if bus3();
    logic [7:0] led8;
    logic [2:0] led3;

    led_pwm_pio #(.NUM_LEDS(8), .PWM_BITS(8), .PRESCALE_BITS(16)) dut8 (
        .clk_clk(clk), .reset_reset_n(rst_n), .avs(bus8), .led_wire_export(led8));
    led_pwm_pio #(.NUM_LEDS(3), .PWM_BITS(8), .PRESCALE_BITS(16)) dut3 (
        .clk_clk(clk), .reset_reset_n(rst_n), .avs(bus3), .led_wire_export(led3));

    int unsigned total = 0;
    int unsigned bad = 0;
    logic [31:0] q;

    task automatic bus_write(input bit sel3, input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        if (sel3) begin
            bus3.avs_address = a; bus3.avs_writedata = d; bus3.avs_write = 1'b1;
        end else begin
            bus8.avs_address = a; bus8.avs_writedata = d; bus8.avs_write = 1'b1;
        end
        @(negedge clk);
        bus3.avs_write = 1'b0;
        bus8.avs_write = 1'b0;
    endtask

    task automatic bus_read(input bit sel3, input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        if (sel3) begin
            bus3.avs_address = a; bus3.avs_read = 1'b1;
        end else begin
            bus8.avs_address = a; bus8.avs_read = 1'b1;
        end
        @(negedge clk);
        bus3.avs_read = 1'b0;
        bus8.avs_read = 1'b0;
        d = sel3 ? bus3.avs_readdata : bus8.avs_readdata;
    endtask

    // STATUS read on dut8 whose sampling edge is k edges after the previous read edge.
    task automatic status_after(input int unsigned k, output logic [31:0] d);
        repeat (k - 1) @(negedge clk);
        bus8.avs_address = ADDR_STATUS;
        bus8.avs_read = 1'b1;
        @(negedge clk);
        bus8.avs_read = 1'b0;
        d = bus8.avs_readdata;
    endtask

    task automatic count_high(input int unsigned n, output int unsigned hi);
        hi = 0;
        repeat (n) begin
            @(negedge clk);
            hi += 32'(led8[0]);
        end
    endtask

    task automatic wait_rise(input bit sel3, input int unsigned limit, output bit ok);
        logic prev;
        logic cur;
        ok = 1'b0;
        prev = sel3 ? led3[0] : led8[0];
        for (int unsigned i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            cur = sel3 ? led3[0] : led8[0];
            if (!prev && cur) ok = 1'b1;
            prev = cur;
        end
    endtask

    task automatic test_reset();
        logic [4:0] addrs [7];
        addrs = '{ADDR_DATA, ADDR_MODE, ADDR_PRESCALE, 5'd16, 5'd23, 5'd5, 5'd31};
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (led8 !== 8'h00 || led3 !== 3'h0) begin
            bad++; $display("FAIL reset_led got=%h/%h exp=00/0", led8, led3);
        end
        total++;
        if (bus8.avs_readdata !== 32'h0) begin
            bad++; $display("FAIL reset_readdata got=%h exp=00000000", bus8.avs_readdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(1'b0, ADDR_STATUS, q);
        total++;
        if (q !== 32'h0001_0000) begin
            bad++; $display("FAIL reset_status got=%h exp=00010000", q);
        end
        for (int i = 0; i < 7; i++) begin
            bus_read(1'b0, addrs[i], q);
            total++;
            if (q !== 32'h0) begin
                bad++; $display("FAIL reset_reg a=%0d got=%h exp=00000000", addrs[i], q);
            end
        end
        bus_read(1'b1, 5'd18, q);
        total++;
        if (q !== 32'h0) begin
            bad++; $display("FAIL reset_duty2_n3 got=%h exp=00000000", q);
        end
    endtask

    task automatic test_static();
        bus_write(1'b0, ADDR_MODE, 32'h0);
        bus_write(1'b0, ADDR_DATA, 32'h0000_00A5);
        total++;
        if (led8 !== 8'h00) begin
            bad++; $display("FAIL static_edge_n got=%h exp=00", led8);
        end
        @(negedge clk);
        total++;
        if (led8 !== 8'hA5) begin
            bad++; $display("FAIL static_edge_n1 got=%h exp=a5", led8);
        end
        bus_read(1'b0, ADDR_DATA, q);
        total++;
        if (q !== 32'h0000_00A5) begin
            bad++; $display("FAIL static_read got=%h exp=000000a5", q);
        end
        bus_write(1'b0, ADDR_DATA, 32'hFFFF_FF5A);
        bus_read(1'b0, ADDR_DATA, q);
        total++;
        if (q !== 32'h0000_005A || led8 !== 8'h5A) begin
            bad++; $display("FAIL static_upper got=%h led=%h exp=0000005a led=5a", q, led8);
        end
        @(negedge clk);
        bus8.avs_address = ADDR_DATA; bus8.avs_writedata = 32'h3C;
        bus8.avs_read = 1'b1; bus8.avs_write = 1'b1;
        @(negedge clk);
        bus8.avs_read = 1'b0; bus8.avs_write = 1'b0;
        total++;
        if (bus8.avs_readdata !== 32'h0000_005A) begin
            bad++; $display("FAIL rw_same_cycle got=%h exp=0000005a", bus8.avs_readdata);
        end
        bus_read(1'b0, ADDR_DATA, q);
        total++;
        if (q !== 32'h0000_003C) begin
            bad++; $display("FAIL rw_write_took got=%h exp=0000003c", q);
        end
    endtask

    task automatic test_pwm();
        int unsigned hi;
        bus_write(1'b0, ADDR_MODE, 32'h01);
        bus_write(1'b0, ADDR_DATA, 32'h01);
        bus_write(1'b0, ADDR_PRESCALE, 32'h0);
        bus_write(1'b0, 5'd16, 32'd64);
        bus_read(1'b0, 5'd16, q);
        total++;
        if (q !== 32'd64) begin
            bad++; $display("FAIL duty0_read got=%h exp=00000040", q);
        end
        repeat (300) @(negedge clk);
        count_high(256, hi);
        total++;
        if (hi != 64) begin
            bad++; $display("FAIL pwm64_high got=%0d exp=64", hi);
        end
        total++;
        if (led8[7:1] !== 7'h0) begin
            bad++; $display("FAIL pwm_others got=%h exp=00", led8[7:1]);
        end
    endtask

    task automatic test_status();
        logic [31:0] s;
        logic [7:0] c;
        int unsigned k;
        bus_read(1'b0, ADDR_STATUS, s);
        c = s[23:16];
        k = 255 - 32'(c);
        if (k == 0) k = 256;
        status_after(k, s);
        total++;
        if (s !== {8'h00, 8'hFF, 15'h0, (c == 8'hFF)}) begin
            bad++; $display("FAIL status_pre_wrap got=%h exp=%h", s, {8'h00, 8'hFF, 15'h0, (c == 8'hFF)});
        end
        status_after(2, s);
        total++;
        if (s !== 32'h0001_0001) begin
            bad++; $display("FAIL status_set_wins got=%h exp=00010001", s);
        end
        status_after(2, s);
        total++;
        if (s !== 32'h0003_0000) begin
            bad++; $display("FAIL status_cleared got=%h exp=00030000", s);
        end
        status_after(252, s);
        total++;
        if (s !== 32'h00FF_0000) begin
            bad++; $display("FAIL status_no_extra got=%h exp=00ff0000", s);
        end
        status_after(2, s);
        total++;
        if (s !== 32'h0001_0001) begin
            bad++; $display("FAIL status_next_wrap got=%h exp=00010001", s);
        end
    endtask

    task automatic test_duty_limits();
        int unsigned hi;
        bus_write(1'b0, 5'd16, 32'd0);
        repeat (300) @(negedge clk);
        count_high(256, hi);
        total++;
        if (hi != 0) begin
            bad++; $display("FAIL duty0_off got=%0d exp=0", hi);
        end
        bus_write(1'b0, 5'd16, 32'd256);
        repeat (300) @(negedge clk);
        count_high(256, hi);
        total++;
        if (hi != 256) begin
            bad++; $display("FAIL duty256_on got=%0d exp=256", hi);
        end
        bus_write(1'b0, 5'd16, 32'hFFFF_FFFF);
        bus_read(1'b0, 5'd16, q);
        total++;
        if (q !== 32'h0000_01FF) begin
            bad++; $display("FAIL duty_width got=%h exp=000001ff", q);
        end
    endtask

    task automatic test_midperiod();
        int unsigned hi0;
        int unsigned hi1;
        bit ok;
        bus_write(1'b0, 5'd16, 32'd64);
        repeat (300) @(negedge clk);
        wait_rise(1'b0, 600, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL mid_rise got=timeout exp=edge");
        end
        hi0 = 1; hi1 = 0;
        for (int unsigned k = 1; k < 512; k++) begin
            @(negedge clk);
            if (k < 256) hi0 += 32'(led8[0]); else hi1 += 32'(led8[0]);
            if (k == 2) begin
                bus8.avs_address = 5'd16; bus8.avs_writedata = 32'd192; bus8.avs_write = 1'b1;
            end
            if (k == 3) bus8.avs_write = 1'b0;
        end
        total++;
        if (hi0 != 64 || hi1 != 192) begin
            bad++; $display("FAIL mid_change got=%0d,%0d exp=64,192", hi0, hi1);
        end
    endtask

    task automatic test_wrap_write();
        int unsigned hi_a;
        int unsigned hi_b;
        int unsigned hi_c;
        bit ok;
        wait_rise(1'b0, 600, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL wrap_rise got=timeout exp=edge");
        end
        hi_a = 1; hi_b = 0; hi_c = 0;
        for (int unsigned k = 1; k < 768; k++) begin
            @(negedge clk);
            if (k < 256) hi_a += 32'(led8[0]);
            else if (k < 512) hi_b += 32'(led8[0]);
            else hi_c += 32'(led8[0]);
            if (k == 254) begin
                bus8.avs_address = 5'd16; bus8.avs_writedata = 32'd64; bus8.avs_write = 1'b1;
            end
            if (k == 255) bus8.avs_write = 1'b0;
        end
        total++;
        if (hi_a != 192 || hi_b != 192 || hi_c != 64) begin
            bad++; $display("FAIL wrap_edge_write got=%0d,%0d,%0d exp=192,192,64", hi_a, hi_b, hi_c);
        end
        bus_read(1'b0, 5'd16, q);
        total++;
        if (q !== 32'd64) begin
            bad++; $display("FAIL wrap_pending got=%h exp=00000040", q);
        end
    endtask

    task automatic test_narrow();
        int unsigned hi;
        logic v1023;
        logic v1024;
        bit ok;
        bus_write(1'b1, ADDR_DATA, 32'hFF);
        bus_write(1'b1, ADDR_MODE, 32'h01);
        bus_write(1'b1, 5'd16, 32'd128);
        bus_write(1'b1, ADDR_PRESCALE, 32'd3);
        bus_write(1'b1, 5'd19, 32'hFFFF_FFFF);
        bus_write(1'b1, 5'd31, 32'hFFFF_FFFF);
        bus_read(1'b1, 5'd19, q);
        total++;
        if (q !== 32'h0) begin
            bad++; $display("FAIL n3_addr19 got=%h exp=00000000", q);
        end
        bus_read(1'b1, 5'd31, q);
        total++;
        if (q !== 32'h0) begin
            bad++; $display("FAIL n3_addr31 got=%h exp=00000000", q);
        end
        bus_read(1'b1, ADDR_DATA, q);
        total++;
        if (q !== 32'h7) begin
            bad++; $display("FAIL n3_data got=%h exp=00000007", q);
        end
        bus_read(1'b1, ADDR_PRESCALE, q);
        total++;
        if (q !== 32'h3) begin
            bad++; $display("FAIL n3_prescale got=%h exp=00000003", q);
        end
        bus_read(1'b1, 5'd16, q);
        total++;
        if (q !== 32'd128) begin
            bad++; $display("FAIL n3_duty0 got=%h exp=00000080", q);
        end
        total++;
        if (led3[2:1] !== 2'b11) begin
            bad++; $display("FAIL n3_static got=%b exp=11", led3[2:1]);
        end
        repeat (1100) @(negedge clk);
        wait_rise(1'b1, 1200, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL n3_rise got=timeout exp=edge");
        end
        hi = 1; v1023 = 1'bx; v1024 = 1'bx;
        for (int unsigned k = 1; k <= 1024; k++) begin
            @(negedge clk);
            if (k < 1024) hi += 32'(led3[0]);
            if (k == 1023) v1023 = led3[0];
            if (k == 1024) v1024 = led3[0];
        end
        total++;
        if (hi != 512 || v1023 !== 1'b0 || v1024 !== 1'b1) begin
            bad++; $display("FAIL n3_period got=%0d,%b,%b exp=512,0,1", hi, v1023, v1024);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        bus_write(1'b0, ADDR_DATA, 32'hFF);
        seen = 1'b0;
        for (int unsigned i = 0; i < 600 && !seen; i++) begin
            @(negedge clk);
            if (led8[0] === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen || led8 !== 8'hFF) begin
            bad++; $display("FAIL mid_reset_pre got=%h exp=ff", led8);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (led8 !== 8'h00 || led3 !== 3'h0 || bus8.avs_readdata !== 32'h0) begin
            bad++; $display("FAIL mid_reset_async got=%h/%h/%h exp=00/0/00000000", led8, led3, bus8.avs_readdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(1'b0, ADDR_STATUS, q);
        total++;
        if (q !== 32'h0001_0000) begin
            bad++; $display("FAIL mid_reset_restart got=%h exp=00010000", q);
        end
        bus_read(1'b0, 5'd16, q);
        total++;
        if (q !== 32'h0 || led8 !== 8'h00) begin
            bad++; $display("FAIL mid_reset_regs got=%h led=%h exp=00000000 led=00", q, led8);
        end
    endtask

    initial begin
        bus8.avs_address = '0; bus8.avs_read = 1'b0; bus8.avs_write = 1'b0; bus8.avs_writedata = '0;
        bus3.avs_address = '0; bus3.avs_read = 1'b0; bus3.avs_write = 1'b0; bus3.avs_writedata = '0;
        rst_n = 1'b0;
        test_reset();
        test_static();
        test_pwm();
        test_status();
        test_duty_limits();
        test_midperiod();
        test_wrap_write();
        test_narrow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
